// File: rtl/kbd_scan_decoder_if.sv
// PS/2 receiver FIFO link: head byte, non-empty flag, overflow level and the active-low pop strobe.
interface kbd_scan_decoder_if;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_nextdata_n;

    // master: the decoder that consumes bytes; slave: the FIFO that supplies them
    modport master (
        input  kb_data,
        input  kb_ready,
        input  kb_overflow,
        output kb_nextdata_n
    );

    modport slave (
        output kb_data,
        output kb_ready,
        output kb_overflow,
        input  kb_nextdata_n
    );
endinterface

// File: rtl/kbd_scan_decoder.sv
// PS/2 scan-code set 2 decoder: pops bytes from the receiver FIFO and tracks E0/F0 prefixes,
// the currently held key, a press counter and a sticky overflow flag.
module kbd_scan_decoder (
    input  logic                       clock,
    input  logic                       reset,
    kbd_scan_decoder_if.master         kb,
    input  logic                       clr,
    output logic                       key_valid,
    output logic [7:0]                 key_code,
    output logic                       key_ext,
    output logic                       key_break,
    output logic                       key_down,
    output logic [7:0]                 cur_code,
    output logic [7:0]                 press_count,
    output logic                       err
);

    typedef enum logic [1:0] {StIdle, StPop, StGap} state_t;

    state_t state_q;
    logic   ext_q;
    logic   brk_q;
    logic   held_ext_q;
    logic   nextdata_n_q;

    logic   is_ext;
    logic   is_brk;
    logic   is_flush;
    logic   held_match;

    assign kb.kb_nextdata_n = nextdata_n_q;

    always_comb begin
        is_ext     = (kb.kb_data == 8'hE0);
        is_brk     = (kb.kb_data == 8'hF0);
        is_flush   = (kb.kb_data == 8'h00) || (kb.kb_data == 8'hFF);
        // Same physical key as the one held: used for both typematic repeat and release
        held_match = key_down && (kb.kb_data == cur_code) && (ext_q == held_ext_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            held_ext_q   <= 1'b0;
            nextdata_n_q <= 1'b1;
            key_valid    <= 1'b0;
            key_code     <= 8'h00;
            key_ext      <= 1'b0;
            key_break    <= 1'b0;
            key_down     <= 1'b0;
            cur_code     <= 8'h00;
            press_count  <= 8'h00;
            err          <= 1'b0;
        end else begin
            nextdata_n_q <= 1'b1;
            key_valid    <= 1'b0;

            if (kb.kb_overflow) begin
                err <= 1'b1;
            end else if (clr) begin
                err <= 1'b0;
            end

            if (clr) begin
                press_count <= 8'h00;
            end

            unique case (state_q)
                StIdle: begin
                    if (kb.kb_ready) begin
                        state_q      <= StPop;
                        nextdata_n_q <= 1'b0;
                        if (is_ext) begin
                            ext_q <= 1'b1;
                        end else if (is_brk) begin
                            brk_q <= 1'b1;
                        end else if (is_flush) begin
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end else begin
                            key_valid <= 1'b1;
                            key_code  <= kb.kb_data;
                            key_ext   <= ext_q;
                            key_break <= brk_q;
                            ext_q     <= 1'b0;
                            brk_q     <= 1'b0;
                            if (brk_q) begin
                                if (held_match) begin
                                    key_down <= 1'b0;
                                    cur_code <= 8'h00;
                                end
                            end else if (!held_match) begin
                                // A new press counts even when clr lands on the same edge
                                press_count <= (clr ? 8'h00 : press_count) + 8'h01;
                                key_down    <= 1'b1;
                                cur_code    <= kb.kb_data;
                                held_ext_q  <= ext_q;
                            end
                        end
                    end
                end
                StPop:   state_q <= StGap;
                StGap:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench for kbd_scan_decoder: a byte-queue FIFO model, a vector table of byte
// sequences with hand-computed results, and hand-written sequences for clr/err/reset/wrap.
module tb_kbd_scan_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       clr;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_down;
    logic [7:0] cur_code;
    logic [7:0] press_count;
    logic       err;

    kbd_scan_decoder_if kb_bus ();

    kbd_scan_decoder dut (
        .clock       (clock),
        .reset       (reset),
        .kb          (kb_bus),
        .clr         (clr),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_break   (key_break),
        .key_down    (key_down),
        .cur_code    (cur_code),
        .press_count (press_count),
        .err         (err)
    );

    always #5 clock = ~clock;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         ev_count = 0;
    int         pop_times[$];
    logic [7:0] fifo_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // FIFO model and monitor both act on the falling edge, away from DUT sampling
    always @(negedge clock) begin
        if (key_valid) ev_count++;
        if (!kb_bus.kb_nextdata_n) begin
            pop_times.push_back(cyc);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        kb_bus.kb_ready = (fifo_q.size() != 0);
        kb_bus.kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr   = 1'b0;
        kb_bus.kb_overflow = 1'b0;
        fifo_q.delete();
        tick(2);
        reset = 1'b0;
        ev_count = 0;
        pop_times.delete();
    endtask

    task automatic drain();
        int k = 0;
        while (fifo_q.size() != 0 && k < 3000) begin
            tick(1);
            k++;
        end
        chk("drain_timeout", fifo_q.size(), 0);
        tick(5);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    typedef struct {
        int              n;
        logic [0:4][7:0] b;
        int              exp_events;
        logic [7:0]      exp_code;
        logic            exp_ext;
        logic            exp_brk;
        logic            exp_down;
        logic [7:0]      exp_cur;
        logic [7:0]      exp_pc;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [39:0] b, input int ev,
                                input logic [7:0] code, input logic ext, input logic brk,
                                input logic down, input logic [7:0] cur, input logic [7:0] pc);
        vec_t v;
        v.n = n; v.b = b; v.exp_events = ev; v.exp_code = code; v.exp_ext = ext;
        v.exp_brk = brk; v.exp_down = down; v.exp_cur = cur; v.exp_pc = pc;
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        vecs[0] = mk(1, 40'h1C_00_00_00_00, 1, 8'h1C, 0, 0, 1, 8'h1C, 8'd1);
        vecs[1] = mk(5, 40'h1C_1C_1C_F0_1C, 4, 8'h1C, 0, 1, 0, 8'h00, 8'd1);
        vecs[2] = mk(5, 40'hE0_75_E0_F0_75, 2, 8'h75, 1, 1, 0, 8'h00, 8'd1);
        vecs[3] = mk(4, 40'hE0_75_F0_75_00, 2, 8'h75, 0, 1, 1, 8'h75, 8'd1);
        vecs[4] = mk(2, 40'h1C_32_00_00_00, 2, 8'h32, 0, 0, 1, 8'h32, 8'd2);
        vecs[5] = mk(3, 40'hF0_00_1C_00_00, 1, 8'h1C, 0, 0, 1, 8'h1C, 8'd1);
        vecs[6] = mk(4, 40'hE0_FF_F0_1C_00, 1, 8'h1C, 0, 1, 0, 8'h00, 8'd0);
        vecs[7] = mk(3, 40'h1C_F0_32_00_00, 2, 8'h32, 0, 1, 1, 8'h1C, 8'd1);
        vecs[8] = mk(3, 40'hE0_1C_1C_00_00, 2, 8'h1C, 0, 0, 1, 8'h1C, 8'd2);
        vecs[9] = mk(5, 40'hE0_1C_1C_F0_1C, 3, 8'h1C, 0, 1, 0, 8'h00, 8'd2);

        kb_bus.kb_data  = 8'h00;
        kb_bus.kb_ready = 1'b0;
        do_reset();

        // Reset state
        chk("rst_nextdata_n", kb_bus.kb_nextdata_n, 1);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_code", key_code, 8'h00);
        chk("rst_key_ext", key_ext, 0);
        chk("rst_key_break", key_break, 0);
        chk("rst_key_down", key_down, 0);
        chk("rst_cur_code", cur_code, 8'h00);
        chk("rst_press_count", press_count, 8'h00);
        chk("rst_err", err, 0);

        // Table-driven byte sequences, each from a fresh reset with all bytes queued up front
        for (int v = 0; v < 10; v++) begin
            int bad_gap;
            do_reset();
            for (int i = 0; i < vecs[v].n; i++) push(vecs[v].b[i]);
            drain();
            bad_gap = 0;
            for (int i = 1; i < pop_times.size(); i++)
                if (pop_times[i] - pop_times[i-1] != 3) bad_gap++;
            chk($sformatf("v%0d_pops", v), pop_times.size(), vecs[v].n);
            chk($sformatf("v%0d_pop_gap", v), bad_gap, 0);
            chk($sformatf("v%0d_events", v), ev_count, vecs[v].exp_events);
            chk($sformatf("v%0d_key_code", v), key_code, vecs[v].exp_code);
            chk($sformatf("v%0d_key_ext", v), key_ext, vecs[v].exp_ext);
            chk($sformatf("v%0d_key_break", v), key_break, vecs[v].exp_brk);
            chk($sformatf("v%0d_key_down", v), key_down, vecs[v].exp_down);
            chk($sformatf("v%0d_cur_code", v), cur_code, vecs[v].exp_cur);
            chk($sformatf("v%0d_press_count", v), press_count, vecs[v].exp_pc);
        end

        // Overflow / clr interplay
        do_reset();
        push(8'h1C);
        drain();
        kb_bus.kb_overflow = 1'b1;
        tick(1);
        kb_bus.kb_overflow = 1'b0;
        tick(3);
        chk("err_sticky", err, 1);
        clr = 1'b1;
        kb_bus.kb_overflow = 1'b1;
        tick(1);
        clr = 1'b0;
        kb_bus.kb_overflow = 1'b0;
        tick(1);
        chk("err_ovf_beats_clr", err, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        chk("clr_err", err, 0);
        chk("clr_press_count", press_count, 8'h00);
        chk("clr_keeps_key_down", key_down, 1);
        chk("clr_keeps_cur_code", cur_code, 8'h1C);

        // clr on the same edge as a new press: the press still counts
        do_reset();
        push(8'h1C);
        drain();
        begin
            int k = 0;
            clr = 1'b1;
            push(8'h32);
            while (!key_valid && k < 50) begin
                tick(1);
                k++;
            end
            clr = 1'b0;
            chk("clr_make_timeout", k < 50, 1);
        end
        tick(1);
        chk("clr_make_press_count", press_count, 8'd1);
        chk("clr_make_cur_code", cur_code, 8'h32);

        // Reset during the POP cycle of an F0 byte discards the prefix
        do_reset();
        push(8'h1C);
        drain();
        push(8'hF0);
        begin
            int k = 0;
            while (kb_bus.kb_nextdata_n && k < 50) begin
                tick(1);
                k++;
            end
            chk("pop_wait_timeout", k < 50, 1);
        end
        reset = 1'b1;
        clr   = 1'b1;
        kb_bus.kb_overflow = 1'b1;
        tick(1);
        reset = 1'b0;
        clr   = 1'b0;
        kb_bus.kb_overflow = 1'b0;
        chk("midpop_nextdata_n", kb_bus.kb_nextdata_n, 1);
        chk("midpop_key_code", key_code, 8'h00);
        chk("midpop_key_down", key_down, 0);
        chk("midpop_cur_code", cur_code, 8'h00);
        chk("midpop_press_count", press_count, 8'h00);
        chk("midpop_err", err, 0);
        fifo_q.delete();
        tick(2);
        push(8'h1C);
        drain();
        chk("after_rst_key_break", key_break, 0);
        chk("after_rst_key_down", key_down, 1);
        chk("after_rst_press_count", press_count, 8'd1);

        // press_count wrap over 256 make/break pairs
        do_reset();
        for (int i = 0; i < 255; i++) begin
            logic [7:0] c;
            c = 8'(1 + (i % 200));
            push(c);
            push(8'hF0);
            push(c);
        end
        drain();
        chk("wrap_255", press_count, 8'hFF);
        chk("wrap_255_key_down", key_down, 0);
        push(8'h44);
        push(8'hF0);
        push(8'h44);
        drain();
        chk("wrap_256", press_count, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
